// File: rtl/a23_mem_defines.sv
// Shared definitions for the A23 banked memory: controller states, address tag
// field and the word-address width helper.
package a23_mem_defines;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

    localparam int TAG_MSB = 31;
    localparam int TAG_LSB = 24;

    function automatic int word_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/a23_mem_bank.sv
// One bank of 32-bit words with per-byte write lanes, combinational read and a
// flat dump of the whole array; reset clears every byte.
module a23_mem_bank
    import a23_mem_defines::*;
#(
    parameter int WORDS = 64,
    parameter int AW    = word_aw(WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [31:0]           rd_data,
    output logic [WORDS*32-1:0]   dump
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int w = 0; w < WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

    for (genvar w = 0; w < WORDS; w++) begin : g_dump
        assign dump[32*w +: 32] = mem[w];
    end

endmodule

// File: rtl/a23_mem_ctrl.sv
// Banked, handshaked memory for the A23 core: streaming loader, registered
// core accesses with byte lanes, write protection and fault capture.
module a23_mem_ctrl
    import a23_mem_defines::*;
#(
    parameter int                   NUM_BANKS  = 5,
    parameter int                   BANK_WORDS = 64,
    parameter logic [NUM_BANKS-1:0] WR_MASK    = 5'b11001,
    parameter logic [NUM_BANKS-1:0] INIT_MASK  = 5'b00111,
    parameter int                   OUT_BANK   = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ld_valid,
    input  logic [31:0]               i_ld_data,
    output logic                      o_ld_ready,
    output logic                      o_ld_done,
    input  logic                      i_m_req,
    input  logic [31:0]               i_m_address,
    input  logic [31:0]               i_m_write,
    input  logic                      i_m_write_en,
    input  logic [3:0]                i_m_byte_enable,
    output logic                      o_m_ack,
    output logic [31:0]               o_m_read,
    output logic                      o_m_err,
    output logic                      o_err_sticky,
    output logic [31:0]               o_err_addr,
    output logic [BANK_WORDS*32-1:0]  o_out
);

    localparam int AW = word_aw(BANK_WORDS);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    function automatic int first_init(input logic [NUM_BANKS-1:0] mask);
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (mask[k]) return k;
        end
        return 0;
    endfunction

    function automatic int last_init(input logic [NUM_BANKS-1:0] mask);
        for (int k = NUM_BANKS - 1; k >= 0; k--) begin
            if (mask[k]) return k;
        end
        return 0;
    endfunction

    localparam int         FIRST_INIT = first_init(INIT_MASK);
    localparam int         LAST_INIT  = last_init(INIT_MASK);
    localparam mem_state_t RESET_ST   = (INIT_MASK != '0) ? LOAD : RUN;

    mem_state_t    state_q, state_d;
    logic [BW-1:0] ld_bank, next_bank;
    logic [AW-1:0] ld_word;
    logic          ld_accept, ld_last;

    logic [7:0]    tag;
    logic [AW-1:0] core_word;
    logic          tag_ok, wr_ok, core_req, fault, core_wr;
    logic [31:0]   sel_rd;

    logic [31:0]             bank_rd   [NUM_BANKS];
    logic [BANK_WORDS*32-1:0] bank_dump [NUM_BANKS];
    logic [NUM_BANKS-1:0]    bank_we;
    logic [AW-1:0]           wr_addr;
    logic [3:0]              wr_be;
    logic [31:0]             wr_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_m_address[1:0], i_m_address[TAG_LSB-1:2+AW]};

    assign ld_accept = (state_q == LOAD) && i_ld_valid;
    assign ld_last   = (int'(ld_bank) == LAST_INIT) && (ld_word == {AW{1'b1}});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= RESET_ST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        o_ld_ready = 1'b0;
        case (state_q)
            LOAD: begin
                o_ld_ready = 1'b1;
                if (ld_accept && ld_last) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = RESET_ST;
        endcase
    end

    // Next INIT bank above the current one; lowest index wins.
    always_comb begin
        next_bank = ld_bank;
        for (int k = NUM_BANKS - 1; k >= 0; k--) begin
            if (INIT_MASK[k] && (k > int'(ld_bank))) next_bank = BW'(k);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ld_bank   <= BW'(FIRST_INIT);
            ld_word   <= '0;
            o_ld_done <= (INIT_MASK == '0);
        end else if (ld_accept) begin
            if (ld_word == {AW{1'b1}}) begin
                ld_word <= '0;
                ld_bank <= next_bank;
            end else begin
                ld_word <= ld_word + 1'b1;
            end
            if (ld_last) o_ld_done <= 1'b1;
        end
    end

    assign tag       = i_m_address[TAG_MSB:TAG_LSB];
    assign core_word = i_m_address[2 +: AW];
    assign tag_ok    = (tag < 8'(NUM_BANKS));
    assign core_req  = (state_q == RUN) && i_m_req;

    always_comb begin
        wr_ok  = 1'b0;
        sel_rd = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (tag == 8'(k)) begin
                wr_ok  = WR_MASK[k];
                sel_rd = bank_rd[k];
            end
        end
    end

    assign fault   = core_req && (!tag_ok || (i_m_write_en && !wr_ok));
    assign core_wr = core_req && i_m_write_en && !fault;

    // Loader and core never write in the same cycle, so one shared port suffices.
    assign wr_addr = ld_accept ? ld_word   : core_word;
    assign wr_be   = ld_accept ? 4'hF      : i_m_byte_enable;
    assign wr_data = ld_accept ? i_ld_data : i_m_write;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        assign bank_we[k] = ld_accept ? (ld_bank == BW'(k)) : (core_wr && (tag == 8'(k)));

        a23_mem_bank #(
            .WORDS (BANK_WORDS),
            .AW    (AW)
        ) u_bank (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .wr_en   (bank_we[k]),
            .wr_addr (wr_addr),
            .wr_be   (wr_be),
            .wr_data (wr_data),
            .rd_addr (core_word),
            .rd_data (bank_rd[k]),
            .dump    (bank_dump[k])
        );
    end

    assign o_out = bank_dump[OUT_BANK];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_m_ack      <= 1'b0;
            o_m_read     <= '0;
            o_m_err      <= 1'b0;
            o_err_sticky <= 1'b0;
            o_err_addr   <= '0;
        end else begin
            o_m_ack  <= core_req;
            o_m_err  <= fault;
            o_m_read <= (core_req && !i_m_write_en && !fault) ? sel_rd : 32'h0;
            if (fault && !o_err_sticky) begin
                o_err_sticky <= 1'b1;
                o_err_addr   <= i_m_address;
            end
        end
    end

endmodule
